bk16_accumulator: RTL and testbench
===================================

# bk16_accumulator

Streaming frame accumulator built around one `BrentKung16b` instance. It sums 16-bit unsigned samples over a frame delimited by `in_last`, and sits directly downstream of the 16-bit prefix adder. The adder's `A`/`B` inputs are driven from the accumulator's low word and the incoming sample. The 17-bit result `S` is consumed by this block: `S[15:0]` becomes the new low word and `S[16]` carries into an upper counter. It then presents the frame total on a valid/ready output port.

## Interface
- `ACC_W`, default 24: accumulator/result width in bits; legal range 17..48.
- `clk`  in  1  rising-edge clock, the single clock of the block.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `clr`  in  1  synchronous clear; abandons any frame in progress.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`.
- `in_data`  in  16  unsigned sample.
- `in_last`  in  1  marks the final sample of a frame; qualified by the handshake.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  `ACC_W`  frame total.
- `out_count`  out  16  number of samples in the frame, saturating at 0xFFFF.
- `out_ovf`  out  1  accumulator exceeded `ACC_W` bits during the frame.

## Operation
- **Adder connections:** the adder instance takes `A = acc[15:0]` and `B = in_data`. Upper bits `acc[ACC_W-1:16]` are an incrementer enabled by `S[16]`. No other adder is used for the low word.
- **States:** two.
  - **ACC:** `in_ready = !clr`, `out_valid = 0`.
  - **HOLD:** `in_ready = 0`, `out_valid = 1`.
- **ACC, beat accepted without `in_last`:**
  - `acc <= {acc_hi + S[16], S[15:0]}`.
  - `cnt <= cnt + 1`, saturating at 0xFFFF.
  - `ovf` is set if the upper increment overflows.
- **ACC, beat accepted with `in_last`:**
  - The post-add values are loaded into `out_sum`, `out_count` and `out_ovf`.
  - `acc`, `cnt` and `ovf` are cleared to 0.
  - The state moves to HOLD.
- **HOLD:** outputs are held stable until `out_ready`. On `out_valid && out_ready` the state returns to ACC. Input is blocked; no beat is accepted in HOLD.
- **Single-beat frame:** a beat with `in_last` on the first sample gives `out_sum = in_data` and `out_count = 1`.
- **Overflow:** without saturation the accumulator wraps modulo 2^`ACC_W`. `ovf` is sticky for the rest of the frame.
- **`clr`:** has priority over every handshake. It clears `acc`, `cnt` and `ovf`, forces state ACC, and clears `out_valid`. `in_ready` is 0 during the `clr` cycle. `out_sum` and `out_count` keep their last values; they are don't-care while `out_valid = 0`.
- **Reset:** all registers go to 0 and the state to ACC. `out_valid`, `out_sum`, `out_count` and `out_ovf` are 0. `in_ready` is forced to 0 while `rst_n` is low.

## Timing
- The adder path is combinational within one cycle. Accumulation throughput is one sample per clock in ACC.
- **Latency:** `out_valid` rises on the clock edge that accepts the `in_last` beat, i.e. it is visible in the following cycle.
- **Frame gap:** at least one cycle, the HOLD cycle. If `out_ready` is high when `out_valid` rises, the next beat can be accepted in the cycle after that.
- `out_*` change only on entry to HOLD, on reset, or on `clr` (valid only).
- **Reset mid-frame:** asynchronous assertion zeroes all outputs immediately. Deassertion is synchronised externally. The first beat is accepted no earlier than the first rising edge after deassertion.
- **`in_valid` low mid-frame:** the accumulator holds its state with no timeout.

## Configuration
- **`BK16_ACC_SAT_EN` defined:**
  - On overflow, `acc` clamps to all ones and stays there for the rest of the frame; further beats still increment `cnt`.
  - `out_sum` reports all ones and `out_ovf = 1`.
- **`BK16_ACC_SAT_EN` undefined:** modulo wrap as described under Operation, with `out_ovf = 1`.

## Test plan
- **Basic frame:** `ACC_W = 24`, beats 0x0001, 0x0002, 0x0003 (last on the third), `out_ready = 1` → `out_valid` for one cycle after the last beat, `out_sum = 0x000006`, `out_count = 3`, `out_ovf = 0`.
- **Carry into upper counter:** beats 0xFFFF, then 0x0001 with last → `out_sum = 0x010000`, `out_count = 2`.
- **Overflow:** 256 × 0xFFFF, then 0x0100 with last →
  - without the macro: `out_sum = 0x000000`, `out_ovf = 1`, `out_count = 257`;
  - with `BK16_ACC_SAT_EN`: `out_sum = 0xFFFFFF`, `out_ovf = 1`.
- **Backpressure:** hold `out_ready = 0` for 5 cycles after a result while `in_valid = 1` → `in_ready = 0`, `out_sum` stable, no beats lost. The next frame starts the cycle after `out_ready` rises.
- **`clr` mid-frame:** accept 0x1234 and 0x1111, assert `clr` for 1 cycle, then send 0x0005 with last → `out_sum = 0x000005`, `out_count = 1`. The beat presented during `clr` is not accepted.
- **Async reset mid-frame:** pull `rst_n` low between edges → `out_valid`, `out_sum`, `out_count`, `out_ovf` and `in_ready` are 0 immediately. After release, the frame 0x0007 with last gives `out_sum = 0x000007`.

Source files
------------

// File: rtl/bk16_accumulator.sv
// bk16_accumulator -- streaming frame accumulator for 16-bit unsigned samples.
//
// Low 16 bits of the running sum are produced by a single Brent-Kung prefix
// adder (BrentKung16b, included below). Its carry-out increments the upper
// bits of the accumulator. A frame ends on the beat that carries in_last.
// The frame total, beat count and overflow flag are then held on a
// valid/ready output until they are taken.
//
// Optional build macro: BK16_ACC_SAT_EN
//   undefined : the accumulator wraps modulo 2^ACC_W; out_ovf flags the wrap.
//   defined   : on overflow the accumulator clamps to all ones for the rest
//               of the frame; out_ovf flags the clamp.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   clr                  synchronous clear; abandons the frame in progress
//   in_valid/in_ready    sample handshake; in_data is the sample, in_last
//                        marks the final sample of a frame
//   out_valid/out_ready  result handshake
//   out_sum              frame total (ACC_W bits)
//   out_count            samples in the frame, saturating at 0xFFFF
//   out_ovf              accumulator exceeded ACC_W bits during the frame

module BrentKung16b (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [16:0] S
);
  // Stage 0 is bitwise generate/propagate. Stages 1..4 are the up-sweep
  // (group spans 2,4,8,16). Stages 5..7 are the down-sweep, which fills in
  // the remaining prefixes. Only generate is carried through the down-sweep.
  // The group propagate it needs is already final in p_s[4].
  logic [15:0] g_s [8];
  logic [15:0] p_s [5];

  assign g_s[0] = A & B;
  assign p_s[0] = A ^ B;

  for (genvar l = 0; l < 4; l++) begin : g_up
    for (genvar i = 0; i < 16; i++) begin : g_bit
      if (((i + 1) % (2 << l)) == 0) begin : g_op
        assign g_s[l+1][i] = g_s[l][i] | (p_s[l][i] & g_s[l][i-(1<<l)]);
        assign p_s[l+1][i] = p_s[l][i] & p_s[l][i-(1<<l)];
      end else begin : g_pass
        assign g_s[l+1][i] = g_s[l][i];
        assign p_s[l+1][i] = p_s[l][i];
      end
    end
  end

  // Down-sweep level l joins the node at i with the complete prefix at
  // i-2^l. Level 2 handles bit 11; level 1 handles bits 5, 9 and 13;
  // level 0 handles the even bits from 2 to 14.
  for (genvar l = 2; l >= 0; l--) begin : g_dn
    for (genvar i = 0; i < 16; i++) begin : g_bit
      if (i >= (2 << l) + (1 << l) - 1 && ((i + 1 - (1 << l)) % (2 << l)) == 0) begin : g_op
        assign g_s[7-l][i] = g_s[6-l][i] | (p_s[4][i] & g_s[6-l][i-(1<<l)]);
      end else begin : g_pass
        assign g_s[7-l][i] = g_s[6-l][i];
      end
    end
  end

  // Carry into bit i+1 is the prefix generate of bits [i:0] (carry-in is 0).
  assign S[0]    = p_s[0][0];
  assign S[15:1] = p_s[0][15:1] ^ g_s[7][14:0];
  assign S[16]   = g_s[7][15];

  // Some group propagates at the top of the up-sweep are not needed.
  logic unused_bk;
  assign unused_bk = ^p_s[4];
endmodule

module bk16_accumulator #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [15:0]      out_count,
  output logic             out_ovf
);
  localparam int HW = ACC_W - 16;

  typedef enum logic {ST_ACC, ST_HOLD} state_t;
  state_t state, state_nxt;

  logic [ACC_W-1:0] acc, acc_nxt;
  logic [15:0]      cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [16:0]      s;
  logic [HW:0]      hi_sum;
  logic             beat;

  BrentKung16b u_bk (
    .A (acc[15:0]),
    .B (in_data),
    .S (s)
  );

  // The upper word is only an incrementer. Its carry-out is the overflow.
  assign hi_sum  = {1'b0, acc[ACC_W-1:16]} + {{HW{1'b0}}, s[16]};
  assign ovf_nxt = ovf | hi_sum[HW];
`ifdef BK16_ACC_SAT_EN
  // ovf is sticky, so once it is set the clamp holds for the whole frame.
  assign acc_nxt = ovf_nxt ? '1 : {hi_sum[HW-1:0], s[15:0]};
`else
  assign acc_nxt = {hi_sum[HW-1:0], s[15:0]};
`endif
  assign cnt_nxt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  // in_ready is also gated by rst_n. During reset the state is already ACC,
  // so the gate keeps the port low while the block is held in reset.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    beat      = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = !clr && rst_n;
        beat     = in_valid && in_ready;
        if (beat && in_last) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_ACC;
      end
      default: state_nxt = ST_ACC;
    endcase
    if (clr) state_nxt = ST_ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (beat) begin
      if (in_last) begin
        out_sum   <= acc_nxt;
        out_count <= cnt_nxt;
        out_ovf   <= ovf_nxt;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        ovf <= ovf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_bk16_accumulator.sv
// Bench for bk16_accumulator (ACC_W = 24). It holds a frame-level model that
// uses plain integer sums, and a per-cycle compare process. Directed frames
// also carry hand-computed literal results.
module tb_bk16_accumulator;
  localparam int    ACC_W = 24;
  localparam longint LIM  = longint'(1) << ACC_W;

  logic             clk = 1'b0;
  logic             rst_n, clr, in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [15:0]      in_data, out_count;
  logic [ACC_W-1:0] out_sum;

  int total = 0;
  int bad   = 0;

  bk16_accumulator #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Frame model: the running total is an integer, and the flags follow the
  // rules for sum, count and overflow.
  longint m_acc, m_osum;
  int     m_cnt, m_ocnt;
  logic   m_ovf, m_oovf, m_hold;

  always @(posedge clk or negedge rst_n) begin : model
    longint sm;
    logic   nov;
    int     c;
    if (!rst_n) begin
      m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_hold <= 0;
      m_osum <= 0; m_ocnt <= 0; m_oovf <= 0;
    end else if (clr) begin
      m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_hold <= 0;
    end else if (m_hold) begin
      if (out_ready) m_hold <= 0;
    end else if (in_valid) begin
      sm  = m_acc + longint'(in_data);
      nov = m_ovf || (sm >= LIM);
`ifdef BK16_ACC_SAT_EN
      if (nov) sm = LIM - 1;
`else
      sm = sm % LIM;
`endif
      c = (m_cnt == 65535) ? 65535 : m_cnt + 1;
      if (in_last) begin
        m_osum <= sm; m_ocnt <= c; m_oovf <= nov; m_hold <= 1;
        m_acc <= 0; m_cnt <= 0; m_ovf <= 0;
      end else begin
        m_acc <= sm; m_cnt <= c; m_ovf <= nov;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    #1;
    chk("cyc_in_ready", 64'(in_ready), 64'(rst_n && !m_hold && !clr));
    chk("cyc_out_valid", 64'(out_valid), 64'(m_hold));
    if (m_hold) begin
      chk("cyc_out_sum", 64'(out_sum), 64'(m_osum));
      chk("cyc_out_count", 64'(out_count), 64'(m_ocnt));
      chk("cyc_out_ovf", 64'(out_ovf), 64'(m_oovf));
    end
  end

  // Present one beat and hold it until it is accepted. Returns on the
  // falling edge after the accepting rising edge.
  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout data=%0h in_ready=%0b want=1", d, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic res(input string nm, input logic [63:0] sum, input logic [63:0] cnt,
                     input logic [63:0] ov);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_sum"},   64'(out_sum), sum);
    chk({nm, "_count"}, 64'(out_count), cnt);
    chk({nm, "_ovf"},   64'(out_ovf), ov);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_sum",   64'(out_sum), 0);
    chk("rst_out_count", 64'(out_count), 0);
    chk("rst_out_ovf",   64'(out_ovf), 0);
    chk("rst_in_ready",  64'(in_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame
    send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 1);
    #1 res("basic", 64'h000006, 3, 0);
    @(negedge clk); #1 chk("basic_one_cycle", 64'(out_valid), 0);

    // carry into the upper word
    send(16'hFFFF, 0); send(16'h0001, 1);
    #1 res("carry", 64'h010000, 2, 0);
    @(negedge clk);

    // overflow: 256 * 0xFFFF + 0x100 = 2^24
    for (int i = 0; i < 256; i++) send(16'hFFFF, 0);
    send(16'h0100, 1);
`ifdef BK16_ACC_SAT_EN
    #1 res("ovf", 64'hFFFFFF, 257, 1);
`else
    #1 res("ovf", 64'h000000, 257, 1);
`endif
    @(negedge clk);

    // backpressure: result held, input blocked, no beat lost
    out_ready = 1'b0;
    send(16'h0010, 0); send(16'h0020, 1);
    in_valid = 1'b1; in_data = 16'h0040; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_sum_stable", 64'(out_sum), 64'h30);
      chk("bp_valid", 64'(out_valid), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_ready_back", 64'(in_ready), 1);
    send(16'h0040, 0); send(16'h0002, 1);
    #1 res("bp_next", 64'h42, 2, 0);
    @(negedge clk);

    // clr mid-frame; the beat shown during clr is dropped
    send(16'h1234, 0); send(16'h1111, 0);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'h9999; in_last = 1'b1;
    #1 chk("clr_in_ready", 64'(in_ready), 0);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    send(16'h0005, 1);
    #1 res("clr", 64'h5, 1, 0);
    @(negedge clk);

    // asynchronous reset between edges, mid-frame
    send(16'h0100, 0); send(16'h0200, 0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_out_sum",   64'(out_sum), 0);
    chk("arst_out_count", 64'(out_count), 0);
    chk("arst_out_ovf",   64'(out_ovf), 0);
    chk("arst_in_ready",  64'(in_ready), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0007, 1);
    #1 res("arst_next", 64'h7, 1, 0);
    @(negedge clk); @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
